// File: rtl/dcache_wt_if.sv
// dcache_wt_if: MEM-stage request port plus burst memory port of the write-through data cache
//   cache_*  : word-addressed rd/wr requests from MEM, read data and waitrequest back
//   mem_*    : burst-read / single-write command port toward the memory arbiter
//   slave    : the cache's view; master: the requester/memory environment's view
interface dcache_wt_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH/8
);
  logic                  cache_rd;
  logic                  cache_wr;
  logic [ADDR_WIDTH-1:0] cache_addr;
  logic [DATA_WIDTH-1:0] cache_wr_data;
  logic [BE_WIDTH-1:0]   cache_wr_be;
  logic [DATA_WIDTH-1:0] cache_data;
  logic                  cache_waitrequest;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [BE_WIDTH-1:0]   mem_wr_be;
  logic [7:0]            mem_burstcount;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  mem_rd_valid;
  logic                  mem_waitrequest;
  modport slave (
    input  cache_rd, cache_wr, cache_addr, cache_wr_data, cache_wr_be,
           mem_rd_data, mem_rd_valid, mem_waitrequest,
    output cache_data, cache_waitrequest,
           mem_rd, mem_wr, mem_addr, mem_wr_data, mem_wr_be, mem_burstcount
  );
  modport master (
    output cache_rd, cache_wr, cache_addr, cache_wr_data, cache_wr_be,
           mem_rd_data, mem_rd_valid, mem_waitrequest,
    input  cache_data, cache_waitrequest,
           mem_rd, mem_wr, mem_addr, mem_wr_data, mem_wr_be, mem_burstcount
  );
endinterface

// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped write-through no-write-allocate data cache with burst line refill
//   clk, rst : clock, asynchronous active-high reset (invalidates every line)
//   bus      : dcache_wt_if.slave carrying the MEM-stage request port and the memory port
module dcache_wt #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH/8,
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input logic        clk,
  input logic        rst,
  dcache_wt_if.slave bus
);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = ADDR_WIDTH - OW - IW;
  typedef enum logic [1:0] {IDLE, REQ, REFILL} state_t;
  state_t                r_state, w_next;
  logic [LINES-1:0]      r_valid;
  logic [TW-1:0]         r_tag [LINES];
  logic [DATA_WIDTH-1:0] r_data [LINES][LINE_WORDS];
  logic [OW-1:0]         r_cnt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [OW-1:0]         w_off;
  logic [IW-1:0]         w_idx, w_ridx;
  logic [TW-1:0]         w_tag;
  logic                  w_hit, w_miss, w_iwr, w_beat, w_last;
  assign w_off  = bus.cache_addr[OW-1:0];
  assign w_idx  = bus.cache_addr[OW +: IW];
  assign w_tag  = bus.cache_addr[ADDR_WIDTH-1 -: TW];
  assign w_ridx = r_base[OW +: IW];
  assign w_hit  = r_valid[w_idx] && r_tag[w_idx] == w_tag;
  // a simultaneous rd+wr is served as a write only
  assign w_iwr  = r_state == IDLE && bus.cache_wr;
  assign w_miss = r_state == IDLE && !bus.cache_wr && bus.cache_rd && !w_hit;
  assign w_beat = r_state == REFILL && bus.mem_rd_valid;
  assign w_last = w_beat && r_cnt == OW'(LINE_WORDS-1);
  assign bus.cache_data = r_data[w_idx][w_off];
  always_comb begin
    w_next                = w_miss ? REQ
                          : (r_state == REQ && !bus.mem_waitrequest) ? REFILL
                          : w_last ? IDLE : r_state;
    bus.mem_rd            = r_state == REQ;
    bus.mem_wr            = w_iwr;
    bus.mem_addr          = r_state == REQ ? r_base : w_iwr ? bus.cache_addr : '0;
    bus.mem_wr_data       = w_iwr ? bus.cache_wr_data : '0;
    bus.mem_wr_be         = w_iwr ? bus.cache_wr_be : '0;
    bus.mem_burstcount    = r_state == REQ ? 8'(LINE_WORDS) : w_iwr ? 8'd1 : 8'd0;
    bus.cache_waitrequest = r_state != IDLE || (w_iwr ? bus.mem_waitrequest : w_miss);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_cnt   <= '0;
      r_base  <= '0;
    end else begin
      r_state <= w_next;
      if (w_miss) r_base <= {bus.cache_addr[ADDR_WIDTH-1:OW], OW'(0)};
      if (r_state == REQ) r_cnt <= '0;
      else if (w_beat) r_cnt <= r_cnt + 1'b1;
      if (w_last) r_valid[w_ridx] <= 1'b1;
    end
  end
  // tag/data need no reset: nothing reads them while the valid bit is clear
  always_ff @(posedge clk) begin
    if (w_last) r_tag[w_ridx] <= r_base[ADDR_WIDTH-1 -: TW];
    if (w_beat) r_data[w_ridx][r_cnt] <= bus.mem_rd_data;
    if (w_iwr && !bus.mem_waitrequest && w_hit)
      for (int b = 0; b < BE_WIDTH; b++)
        if (bus.cache_wr_be[b]) r_data[w_idx][w_off][8*b +: 8] <= bus.cache_wr_data[8*b +: 8];
  end
endmodule

// File: tb/tb_dcache_wt.sv
// tb_dcache_wt: directed plus random checks of dcache_wt against a memory-image reference model
module tb_dcache_wt;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dcache_wt_if bus();
  dcache_wt dut (.clk(clk), .rst(rst), .bus(bus));
  int n_tests = 0;
  int n_fail  = 0;
  // the cache is write-through, so any cached word always equals the memory image
  logic [31:0] mem [logic [31:0]];
  bit          present [64];
  logic [31:0] line_of [64];
  function automatic logic [31:0] mget(logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction
  function automatic bit is_hit(logic [31:0] a);
    return present[a[7:2]] && line_of[a[7:2]] == (a >> 2);
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle();
    @(negedge clk);
    chk("idle_wait", 32'(bus.cache_waitrequest), 0);
    chk("idle_mem_rd", 32'(bus.mem_rd), 0);
    chk("idle_mem_wr", 32'(bus.mem_wr), 0);
    chk("idle_mem_addr", bus.mem_addr, 0);
    chk("idle_mem_data", bus.mem_wr_data, 0);
    chk("idle_mem_be", 32'(bus.mem_wr_be), 0);
  endtask
  task automatic do_read(logic [31:0] a, int stall);
    bit h;
    logic [31:0] base;
    h = is_hit(a);
    base = {a[31:2], 2'b00};
    bus.cache_rd = 1'b1;
    bus.cache_addr = a;
    @(negedge clk);
    chk("rd_wait", 32'(bus.cache_waitrequest), 32'(!h));
    chk("rd_no_mem_wr", 32'(bus.mem_wr), 0);
    if (h) begin
      chk("rd_no_mem_rd", 32'(bus.mem_rd), 0);
      chk("rd_hit_data", bus.cache_data, mget(a));
    end else begin
      tick();
      bus.mem_waitrequest = 1'b1;
      for (int i = 0; i <= stall; i++) begin
        if (i == stall) bus.mem_waitrequest = 1'b0;
        @(negedge clk);
        chk("req_mem_rd", 32'(bus.mem_rd), 1);
        chk("req_addr", bus.mem_addr, base);
        chk("req_burst", 32'(bus.mem_burstcount), 4);
        chk("req_wait", 32'(bus.cache_waitrequest), 1);
        tick();
      end
      for (int k = 0; k < 4; k++) begin
        while ($urandom_range(0, 2) == 0) begin
          bus.mem_rd_valid = 1'b0;
          @(negedge clk);
          chk("refill_wait", 32'(bus.cache_waitrequest), 1);
          chk("refill_no_mem_rd", 32'(bus.mem_rd), 0);
          tick();
        end
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data = mget(base + 32'(k));
        tick();
      end
      bus.mem_rd_valid = 1'b0;
      bus.mem_rd_data = '0;
      present[a[7:2]] = 1'b1;
      line_of[a[7:2]] = a >> 2;
      @(negedge clk);
      chk("fill_wait", 32'(bus.cache_waitrequest), 0);
      chk("fill_data", bus.cache_data, mget(a));
      chk("fill_no_mem_rd", 32'(bus.mem_rd), 0);
    end
    tick();
    bus.cache_rd = 1'b0;
  endtask
  task automatic do_write(logic [31:0] a, logic [31:0] d, logic [3:0] be, int stall, bit rd_too);
    logic [31:0] w;
    bus.cache_wr = 1'b1;
    bus.cache_rd = rd_too;
    bus.cache_addr = a;
    bus.cache_wr_data = d;
    bus.cache_wr_be = be;
    bus.mem_waitrequest = stall > 0;
    for (int i = 0; i <= stall; i++) begin
      if (i == stall) bus.mem_waitrequest = 1'b0;
      @(negedge clk);
      chk("wr_mem_wr", 32'(bus.mem_wr), 1);
      chk("wr_mem_rd", 32'(bus.mem_rd), 0);
      chk("wr_addr", bus.mem_addr, a);
      chk("wr_data", bus.mem_wr_data, d);
      chk("wr_be", 32'(bus.mem_wr_be), 32'(be));
      chk("wr_burst", 32'(bus.mem_burstcount), 1);
      chk("wr_wait", 32'(bus.cache_waitrequest), 32'(i < stall));
      tick();
    end
    w = mget(a);
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    mem[a] = w;
    bus.cache_wr = 1'b0;
    bus.cache_rd = 1'b0;
    bus.cache_wr_be = '0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] a;
    bus.cache_rd = 0; bus.cache_wr = 0; bus.cache_addr = 0; bus.cache_wr_data = 0;
    bus.cache_wr_be = 0; bus.mem_rd_data = 0; bus.mem_rd_valid = 0; bus.mem_waitrequest = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_idle();
    tick();
    for (int k = 0; k < 4; k++) mem[32'h40 + 32'(k)] = 32'hDEADBE00 + 32'(k);
    do_read(32'h40, 0);
    do_read(32'h42, 0);
    do_write(32'h41, 32'h11223344, 4'b0011, 0, 0);
    do_read(32'h41, 0);
    chk("t2_merged", mem[32'h41], 32'hDEAD3344);
    do_write(32'h1000, 32'hCAFEF00D, 4'hF, 0, 0);
    do_read(32'h1000, 0);
    do_read(32'h140, 1);
    do_read(32'h40, 2);
    do_read(32'h200, 3);
    do_write(32'h44, 32'hA5A5A5A5, 4'hF, 3, 0);
    do_read(32'h44, 0);
    do_write(32'h42, 32'h55667788, 4'b1100, 1, 1);
    do_read(32'h42, 0);
    do_write(32'h43, 32'hFFFFFFFF, 4'b0000, 0, 0);
    do_read(32'h43, 0);
    do_read(32'h140, 0);
    bus.cache_rd = 1'b1;
    bus.cache_addr = 32'h40;
    @(negedge clk);
    chk("rst_miss_wait", 32'(bus.cache_waitrequest), 1);
    tick();
    @(negedge clk);
    chk("rst_req_rd", 32'(bus.mem_rd), 1);
    tick();
    for (int k = 0; k < 2; k++) begin
      bus.mem_rd_valid = 1'b1;
      bus.mem_rd_data = mget(32'h40 + 32'(k));
      tick();
    end
    bus.mem_rd_valid = 1'b0;
    bus.cache_rd = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_async_mem_rd", 32'(bus.mem_rd), 0);
    chk("rst_async_wait", 32'(bus.cache_waitrequest), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) present[i] = 1'b0;
    for (int k = 2; k < 4; k++) begin
      bus.mem_rd_valid = 1'b1;
      bus.mem_rd_data = $urandom;
      tick();
    end
    bus.mem_rd_valid = 1'b0;
    check_idle();
    tick();
    do_read(32'h40, 0);
    do_read(32'h200, 0);
    for (int n = 0; n < 200; n++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) do_read(a, $urandom_range(0, 2));
      else do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), 1'b0);
    end
    check_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
